control: RTL and testbench
==========================

# control

Multicycle control FSM that sequences the RV32I datapath. It walks each instruction through fetch, decode, execute, memory and writeback. In each state it drives the datapath load enables and mux selects, along with the memory request and byte enables. It sits between the datapath (opcode/funct/br_en in, controls out) and the memory port (mem_resp in, mem_read/mem_write/mem_byte_enable out).

## Interface
- No parameters; all widths come from rv32i_types.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- opcode  in  rv32i_opcode  from IR
- funct3  in  3  from IR
- funct7  in  7  from IR
- br_en  in  1  comparator result
- select  in  2  MAR[1:0], byte offset
- mem_resp  in  1  memory completion, single-cycle pulse
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register loads
- pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel  out  enum  datapath selects
- aluop  out  alu_ops
- cmpop  out  branch_funct3_t
- mem_read, mem_write  out  1
- mem_byte_enable  out  4

## Operation
- Moore outputs, decoded combinationally from state plus IR fields.
- Defaults in every state:
  - all loads 0, mem_read/mem_write 0, mem_byte_enable 4'b1111
  - selects: pc_plus4 / rs1_out / i_imm / alu_out / pc_out / rs2_out
  - aluop = alu_add, cmpop = funct3
- Fetch and decode:
  - FETCH1: marmux=pc_out, load_mar → FETCH2.
  - FETCH2: mem_read, load_mdr; hold until mem_resp, then → FETCH3.
  - FETCH3: load_ir → DECODE.
  - DECODE: no loads; branch on opcode. An unknown opcode asserts load_pc (pc_plus4) and → FETCH1.
- Execute states; each asserts load_regfile/load_pc as listed, then → FETCH1 unless noted:
  - LUI: regfilemux=u_imm, load_regfile, load_pc.
  - AUIPC: alumux1=pc_out, alumux2=u_imm, add, load_regfile, load_pc.
  - IMM: alumux2=i_imm, load_regfile, load_pc.
    - slt/sltu: cmpmux=i_imm, cmpop=blt/bltu, regfilemux=br_en.
    - sr: funct7[5] ? alu_sra : alu_srl.
    - Other funct3: aluop = funct3.
  - REG: alumux2=rs2_out, load_regfile, load_pc.
    - add: funct7[5] ? alu_sub : alu_add.
    - sr: as IMM.
    - slt/sltu: as IMM but cmpmux=rs2_out.
  - BR: alumux1=pc_out, alumux2=b_imm, add, cmpmux=rs2_out, load_pc; pcmux = br_en ? alu_out : pc_plus4.
  - JAL: regfilemux=pc_plus4, load_regfile; alumux1=pc_out, alumux2=j_imm, pcmux=alu_out, load_pc.
  - JALR: regfilemux=pc_plus4, load_regfile; alumux2=i_imm, pcmux=alu_mod2, load_pc.
- Memory states:
  - CALC_ADDR: marmux=alu_out, load_mar; alumux2 = i_imm for loads, s_imm for stores. Stores also assert load_data_out. → LD1 or ST1.
  - LD1: mem_read, load_mdr; hold until mem_resp → LD2.
  - LD2: regfilemux = lw/lb/lbu/lh/lhu per funct3; load_regfile, load_pc.
  - ST1: mem_write; hold until mem_resp → ST2.
  - ST2: load_pc.
- Store byte enables in ST1:
  - sw: 4'b1111
  - sh: 4'b0011 << select
  - sb: 4'b0001 << select
- mem_resp is ignored in non-waiting states.

## Timing
- rst low: state = FETCH1 immediately; all outputs take FETCH1 values (load_mar=1, everything else inactive). Exit is synchronous, on the first clk edge after rst rises.
- Reset mid-memory (FETCH2/LD1/ST1): mem_read/mem_write deassert in the same cycle.
- Cycle counts, with mem_resp in the same cycle as the request:
  - ALU/LUI/AUIPC/BR/JAL/JALR: 5 cycles.
  - Load/store: 7 cycles.
  - Each extra memory wait cycle adds 1.
- mem_read/mem_write stay asserted, with stable address, continuously until the cycle mem_resp is seen.
- rd = x0 writes are allowed; regfile discards them.

## Structure
- Package rv32i_types: control_state_t enum (FETCH1…ST2).
- Mux enums are reused from the existing pcmux/alumux/regfilemux/marmux/cmpmux packages.
- One sub-module, ctrl_funct_decode (combinational): maps opcode/funct3/funct7/select to aluop, cmpop, regfilemux load select and mem_byte_enable.
- The FSM has a registered next-state process and a combinational output process.

## Test plan
- Reset: hold rst=0 mid-FETCH2 → state FETCH1, mem_read=0, load_mar=1. Release → FETCH2 on the next edge.
- addi x1,x0,5 with mem_resp latency 0 → load_regfile exactly once, at cycle 5, with regfilemux=alu_out, aluop=alu_add, alumux2=i_imm.
- beq, taken vs not-taken: br_en=1 → pcmux=alu_out, alumux2=b_imm; br_en=0 → pcmux=pc_plus4. Both assert load_pc in cycle 5.
- sb with select=2, mem_resp delayed 3 cycles → mem_byte_enable=4'b0100. mem_write is held for 4 cycles, then ST2 asserts load_pc.
- lhu: LD2 has regfilemux=lhu, load_regfile=1. sub (funct7=0x20) → aluop=alu_sub. srai → alu_sra.
- Illegal opcode 7'h7F → DECODE asserts load_pc with pc_plus4; no load_regfile, no mem access.

Source files
------------

// File: rtl/control_pkg.sv
// Shared type definitions for the RV32I multicycle control slice.
//   pcmux, marmux, cmpmux, alumux, regfilemux : datapath mux select encodings
//   rv32i_types : opcodes, funct3 groupings, ALU ops, control FSM states
// No ports; imported by the interface, the FSM and the decode sub-module.

package pcmux;
    typedef enum logic [1:0] {
        pc_plus4 = 2'b00,
        alu_out  = 2'b01,
        alu_mod2 = 2'b10
    } pcmux_sel_t;
endpackage

package marmux;
    typedef enum logic {
        pc_out  = 1'b0,
        alu_out = 1'b1
    } marmux_sel_t;
endpackage

package cmpmux;
    typedef enum logic {
        rs2_out = 1'b0,
        i_imm   = 1'b1
    } cmpmux_sel_t;
endpackage

package alumux;
    typedef enum logic {
        rs1_out = 1'b0,
        pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        i_imm   = 3'd0,
        u_imm   = 3'd1,
        b_imm   = 3'd2,
        s_imm   = 3'd3,
        j_imm   = 3'd4,
        rs2_out = 3'd5
    } alumux2_sel_t;
endpackage

package regfilemux;
    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;
endpackage

package rv32i_types;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    // Encodings chosen so add/sll/xor/or/and equal their funct3 values.
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_LUI, S_AUIPC, S_IMM, S_REG, S_BR, S_JAL, S_JALR,
        CALC_ADDR, LD1, LD2, ST1, ST2
    } control_state_t;
endpackage

// File: rtl/control_if.sv
// Bundle between the control FSM and the datapath / memory port.
//   master : control side (reads IR fields, br_en, select, mem_resp; drives
//            register loads, mux selects, ALU/compare ops and memory request)
//   slave  : datapath + memory side (the mirror image)

interface control_if;
    import rv32i_types::*;

    rv32i_opcode                 opcode;
    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic                        br_en;
    logic [1:0]                  select;
    logic                        mem_resp;

    logic                        load_pc;
    logic                        load_ir;
    logic                        load_regfile;
    logic                        load_mar;
    logic                        load_mdr;
    logic                        load_data_out;
    pcmux::pcmux_sel_t           pcmux_sel;
    alumux::alumux1_sel_t        alumux1_sel;
    alumux::alumux2_sel_t        alumux2_sel;
    regfilemux::regfilemux_sel_t regfilemux_sel;
    marmux::marmux_sel_t         marmux_sel;
    cmpmux::cmpmux_sel_t         cmpmux_sel;
    alu_ops                      aluop;
    branch_funct3_t              cmpop;
    logic                        mem_read;
    logic                        mem_write;
    logic [3:0]                  mem_byte_enable;

    modport master (
        input  opcode, funct3, funct7, br_en, select, mem_resp,
        output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
               cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable
    );

    modport slave (
        output opcode, funct3, funct7, br_en, select, mem_resp,
        input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
               pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
               cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable
    );
endinterface

// File: rtl/ctrl_funct_decode.sv
// Combinational funct-field decode for the control FSM.
//   opcode_i, funct3_i, funct7_i : IR fields
//   select_i                     : byte offset of the store address (MAR[1:0])
//   aluop_o                      : ALU op for register/immediate arithmetic
//   cmpop_o                      : comparator op (slt/sltu remapped to blt/bltu)
//   ld_sel_o                     : regfile write-back select for loads
//   mem_byte_enable_o            : store byte lanes
// Outputs are only meaningful in the FSM states that consume them.

module ctrl_funct_decode
    import rv32i_types::*;
(
    input  rv32i_opcode                 opcode_i,
    input  logic [2:0]                  funct3_i,
    input  logic [6:0]                  funct7_i,
    input  logic [1:0]                  select_i,
    output alu_ops                      aluop_o,
    output branch_funct3_t              cmpop_o,
    output regfilemux::regfilemux_sel_t ld_sel_o,
    output logic [3:0]                  mem_byte_enable_o
);
    // Only funct7[5] distinguishes sub/sra; the rest is don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        aluop_o = alu_ops'(funct3_i);
        case (arith_funct3_t'(funct3_i))
            slt, sltu: aluop_o = alu_add;
            sr:        aluop_o = funct7_i[5] ? alu_sra : alu_srl;
            add: begin
                // Immediate add has no subtract form; bit 30 is part of the imm.
                if (opcode_i == op_reg && funct7_i[5]) aluop_o = alu_sub;
            end
            default: ;
        endcase
    end

    always_comb begin
        cmpop_o = branch_funct3_t'(funct3_i);
        case (arith_funct3_t'(funct3_i))
            slt:     cmpop_o = blt;
            sltu:    cmpop_o = bltu;
            default: ;
        endcase
    end

    always_comb begin
        case (load_funct3_t'(funct3_i))
            lb:      ld_sel_o = regfilemux::lb;
            lh:      ld_sel_o = regfilemux::lh;
            lbu:     ld_sel_o = regfilemux::lbu;
            lhu:     ld_sel_o = regfilemux::lhu;
            default: ld_sel_o = regfilemux::lw;
        endcase
    end

    always_comb begin
        case (store_funct3_t'(funct3_i))
            sh:      mem_byte_enable_o = 4'b0011 << select_i;
            sb:      mem_byte_enable_o = 4'b0001 << select_i;
            default: mem_byte_enable_o = 4'b1111;
        endcase
    end
endmodule

// File: rtl/control.sv
// Multicycle RV32I control FSM: FETCH1-3, DECODE, one execute state per
// instruction class, and CALC_ADDR/LD1/LD2/ST1/ST2 for memory operations.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset (forces FETCH1)
//   bus  : control_if.master (IR fields, br_en, select, mem_resp in;
//          loads, mux selects, aluop, cmpop, memory request out)
// Outputs are Moore-style: decoded from the state plus the IR fields.

module control
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    control_if.master bus
);
    control_state_t              state_q, state_d;
    alu_ops                      dec_aluop;
    branch_funct3_t              dec_cmpop;
    regfilemux::regfilemux_sel_t dec_ld_sel;
    logic [3:0]                  dec_mbe;
    logic                        is_slt;

    ctrl_funct_decode u_decode (
        .opcode_i          (bus.opcode),
        .funct3_i          (bus.funct3),
        .funct7_i          (bus.funct7),
        .select_i          (bus.select),
        .aluop_o           (dec_aluop),
        .cmpop_o           (dec_cmpop),
        .ld_sel_o          (dec_ld_sel),
        .mem_byte_enable_o (dec_mbe)
    );

    assign is_slt = (arith_funct3_t'(bus.funct3) == slt) ||
                    (arith_funct3_t'(bus.funct3) == sltu);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= FETCH1;
        else      state_q <= state_d;
    end

    always_comb begin
        // Next state
        state_d = state_q;
        case (state_q)
            FETCH1: state_d = FETCH2;
            FETCH2: if (bus.mem_resp) state_d = FETCH3;
            FETCH3: state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    op_lui:            state_d = S_LUI;
                    op_auipc:          state_d = S_AUIPC;
                    op_imm:            state_d = S_IMM;
                    op_reg:            state_d = S_REG;
                    op_br:             state_d = S_BR;
                    op_jal:            state_d = S_JAL;
                    op_jalr:           state_d = S_JALR;
                    op_load, op_store: state_d = CALC_ADDR;
                    default:           state_d = FETCH1;
                endcase
            end
            CALC_ADDR: state_d = (bus.opcode == op_store) ? ST1 : LD1;
            LD1:       if (bus.mem_resp) state_d = LD2;
            ST1:       if (bus.mem_resp) state_d = ST2;
            default:   state_d = FETCH1;
        endcase

        // Outputs
        bus.load_pc         = 1'b0;
        bus.load_ir         = 1'b0;
        bus.load_regfile    = 1'b0;
        bus.load_mar        = 1'b0;
        bus.load_mdr        = 1'b0;
        bus.load_data_out   = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 4'b1111;
        bus.pcmux_sel       = pcmux::pc_plus4;
        bus.alumux1_sel     = alumux::rs1_out;
        bus.alumux2_sel     = alumux::i_imm;
        bus.regfilemux_sel  = regfilemux::alu_out;
        bus.marmux_sel      = marmux::pc_out;
        bus.cmpmux_sel      = cmpmux::rs2_out;
        bus.aluop           = alu_add;
        bus.cmpop           = branch_funct3_t'(bus.funct3);

        case (state_q)
            FETCH1: bus.load_mar = 1'b1;
            FETCH2: begin
                bus.mem_read = 1'b1;
                bus.load_mdr = 1'b1;
            end
            FETCH3: bus.load_ir = 1'b1;
            DECODE: begin
                // Unknown opcode: skip it by advancing the PC.
                if (state_d == FETCH1) bus.load_pc = 1'b1;
            end
            S_LUI: begin
                bus.regfilemux_sel = regfilemux::u_imm;
                bus.load_regfile   = 1'b1;
                bus.load_pc        = 1'b1;
            end
            S_AUIPC: begin
                bus.alumux1_sel  = alumux::pc_out;
                bus.alumux2_sel  = alumux::u_imm;
                bus.load_regfile = 1'b1;
                bus.load_pc      = 1'b1;
            end
            S_IMM: begin
                bus.alumux2_sel  = alumux::i_imm;
                bus.aluop        = dec_aluop;
                bus.load_regfile = 1'b1;
                bus.load_pc      = 1'b1;
                if (is_slt) begin
                    bus.cmpmux_sel     = cmpmux::i_imm;
                    bus.cmpop          = dec_cmpop;
                    bus.regfilemux_sel = regfilemux::br_en;
                end
            end
            S_REG: begin
                bus.alumux2_sel  = alumux::rs2_out;
                bus.aluop        = dec_aluop;
                bus.load_regfile = 1'b1;
                bus.load_pc      = 1'b1;
                if (is_slt) begin
                    bus.cmpmux_sel     = cmpmux::rs2_out;
                    bus.cmpop          = dec_cmpop;
                    bus.regfilemux_sel = regfilemux::br_en;
                end
            end
            S_BR: begin
                bus.alumux1_sel = alumux::pc_out;
                bus.alumux2_sel = alumux::b_imm;
                bus.cmpmux_sel  = cmpmux::rs2_out;
                bus.pcmux_sel   = bus.br_en ? pcmux::alu_out : pcmux::pc_plus4;
                bus.load_pc     = 1'b1;
            end
            S_JAL: begin
                bus.regfilemux_sel = regfilemux::pc_plus4;
                bus.load_regfile   = 1'b1;
                bus.alumux1_sel    = alumux::pc_out;
                bus.alumux2_sel    = alumux::j_imm;
                bus.pcmux_sel      = pcmux::alu_out;
                bus.load_pc        = 1'b1;
            end
            S_JALR: begin
                bus.regfilemux_sel = regfilemux::pc_plus4;
                bus.load_regfile   = 1'b1;
                bus.alumux2_sel    = alumux::i_imm;
                bus.pcmux_sel      = pcmux::alu_mod2;
                bus.load_pc        = 1'b1;
            end
            CALC_ADDR: begin
                bus.marmux_sel = marmux::alu_out;
                bus.load_mar   = 1'b1;
                if (bus.opcode == op_store) begin
                    bus.alumux2_sel   = alumux::s_imm;
                    bus.load_data_out = 1'b1;
                end
            end
            LD1: begin
                bus.mem_read = 1'b1;
                bus.load_mdr = 1'b1;
            end
            LD2: begin
                bus.regfilemux_sel = dec_ld_sel;
                bus.load_regfile   = 1'b1;
                bus.load_pc        = 1'b1;
            end
            ST1: begin
                bus.mem_write       = 1'b1;
                bus.mem_byte_enable = dec_mbe;
            end
            ST2: bus.load_pc = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control.sv
// Bench for control: builds a per-cycle plan of inputs and expected outputs
// from an instruction-level model, drives it, and compares every cycle.

module tb_control;
    import rv32i_types::*;

    typedef struct packed {
        logic       ld_pc, ld_ir, ld_rf, ld_mar, ld_mdr, ld_do;
        logic [1:0] pcmux;
        logic       alumux1;
        logic [2:0] alumux2;
        logic [3:0] rfmux;
        logic       marmux, cmpmux;
        logic [2:0] aluop, cmpop;
        logic       mrd, mwr;
        logic [3:0] mbe;
    } outs_t;

    typedef struct {
        logic       rst, resp, br;
        logic [1:0] sel;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        outs_t      exp;
        string      name;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    control_if bus();

    control dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    step_t plan[$];
    step_t exp_q[$];
    step_t cmp_s;
    int checks = 0;
    int errors = 0;

    logic       cur_br;
    logic [1:0] cur_sel;
    logic [6:0] cur_op, cur_f7;
    logic [2:0] cur_f3;

    // ---------------- model ----------------
    function automatic outs_t base(input logic [2:0] f3);
        outs_t o;
        o = '0;
        o.mbe     = 4'b1111;
        o.pcmux   = pcmux::pc_plus4;
        o.alumux1 = alumux::rs1_out;
        o.alumux2 = alumux::i_imm;
        o.rfmux   = regfilemux::alu_out;
        o.marmux  = marmux::pc_out;
        o.cmpmux  = cmpmux::rs2_out;
        o.aluop   = alu_add;
        o.cmpop   = f3;
        return o;
    endfunction

    function automatic logic [2:0] model_aluop(input logic is_reg, input logic [2:0] f3,
                                               input logic [6:0] f7);
        case (f3)
            3'd0:    return (is_reg && f7 == 7'h20) ? alu_sub : alu_add;
            3'd1:    return alu_sll;
            3'd4:    return alu_xor;
            3'd5:    return f7[5] ? alu_sra : alu_srl;
            3'd6:    return alu_or;
            3'd7:    return alu_and;
            default: return alu_add;
        endcase
    endfunction

    // Byte lanes touched by a store of the given size starting at byte sel.
    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] sel);
        int size;
        logic [3:0] m;
        size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (size == 4) return 4'b1111;
        m = '0;
        for (int b = 0; b < 4; b++)
            m[b] = (b >= int'(sel)) && (b < int'(sel) + size);
        return m;
    endfunction

    function automatic logic [3:0] load_sel(input logic [2:0] f3);
        case (f3)
            3'd0:    return regfilemux::lb;
            3'd1:    return regfilemux::lh;
            3'd4:    return regfilemux::lbu;
            3'd5:    return regfilemux::lhu;
            default: return regfilemux::lw;
        endcase
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {op_lui, op_auipc, op_jal, op_jalr, op_br,
                          op_load, op_store, op_imm, op_reg};
    endfunction

    function automatic outs_t exec_outs(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic br);
        outs_t o;
        o = base(f3);
        case (op)
            op_lui: begin
                o.rfmux = regfilemux::u_imm; o.ld_rf = 1; o.ld_pc = 1;
            end
            op_auipc: begin
                o.alumux1 = alumux::pc_out; o.alumux2 = alumux::u_imm;
                o.ld_rf = 1; o.ld_pc = 1;
            end
            op_imm, op_reg: begin
                o.ld_rf = 1; o.ld_pc = 1;
                o.alumux2 = (op == op_reg) ? alumux::rs2_out : alumux::i_imm;
                o.aluop = model_aluop(op == op_reg, f3, f7);
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    o.rfmux  = regfilemux::br_en;
                    o.cmpmux = (op == op_reg) ? cmpmux::rs2_out : cmpmux::i_imm;
                    o.cmpop  = (f3 == 3'd2) ? blt : bltu;
                end
            end
            op_br: begin
                o.alumux1 = alumux::pc_out; o.alumux2 = alumux::b_imm; o.ld_pc = 1;
                o.pcmux = br ? pcmux::alu_out : pcmux::pc_plus4;
            end
            op_jal: begin
                o.rfmux = regfilemux::pc_plus4; o.ld_rf = 1;
                o.alumux1 = alumux::pc_out; o.alumux2 = alumux::j_imm;
                o.pcmux = pcmux::alu_out; o.ld_pc = 1;
            end
            op_jalr: begin
                o.rfmux = regfilemux::pc_plus4; o.ld_rf = 1;
                o.alumux2 = alumux::i_imm; o.pcmux = pcmux::alu_mod2; o.ld_pc = 1;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic push(input logic r, input logic resp, input outs_t o, input string tag);
        step_t s;
        s.rst = r; s.resp = resp; s.br = cur_br; s.sel = cur_sel;
        s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7; s.exp = o; s.name = tag;
        plan.push_back(s);
    endtask

    task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic br, input logic [1:0] sel);
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_br = br; cur_sel = sel;
    endtask

    // One full instruction: flat/mlat = extra fetch/data wait cycles; noisy
    // drives mem_resp high in every state that must ignore it.
    task automatic add_insn(input string nm, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic br, input logic [1:0] sel,
                            input int flat, input int mlat, input logic noisy,
                            output int n);
        outs_t o;
        int n0;
        bit st;
        n0 = plan.size();
        set_insn(op, f3, f7, br, sel);
        o = base(f3); o.ld_mar = 1;
        push(1, noisy, o, {nm, ".fetch1"});
        for (int i = 0; i <= flat; i++) begin
            o = base(f3); o.mrd = 1; o.ld_mdr = 1;
            push(1, i == flat, o, {nm, ".fetch2"});
        end
        o = base(f3); o.ld_ir = 1;
        push(1, noisy, o, {nm, ".fetch3"});
        o = base(f3);
        if (!known_op(op)) o.ld_pc = 1;
        push(1, noisy, o, {nm, ".decode"});
        if (op == op_load || op == op_store) begin
            st = (op == op_store);
            o = base(f3); o.marmux = marmux::alu_out; o.ld_mar = 1;
            o.alumux2 = st ? alumux::s_imm : alumux::i_imm;
            o.ld_do = st;
            push(1, noisy, o, {nm, ".calc"});
            for (int i = 0; i <= mlat; i++) begin
                o = base(f3);
                if (st) begin o.mwr = 1; o.mbe = byte_mask(f3, sel); end
                else    begin o.mrd = 1; o.ld_mdr = 1; end
                push(1, i == mlat, o, {nm, ".mem"});
            end
            o = base(f3); o.ld_pc = 1;
            if (!st) begin o.ld_rf = 1; o.rfmux = load_sel(f3); end
            push(1, noisy, o, {nm, ".wb"});
        end else if (known_op(op)) begin
            push(1, noisy, exec_outs(op, f3, f7, br), {nm, ".exec"});
        end
        n = plan.size() - n0;
    endtask

    task automatic check_lit(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            outs_t act;
            cmp_s = exp_q.pop_front();
            act = {bus.load_pc, bus.load_ir, bus.load_regfile, bus.load_mar, bus.load_mdr,
                   bus.load_data_out, bus.pcmux_sel, bus.alumux1_sel, bus.alumux2_sel,
                   bus.regfilemux_sel, bus.marmux_sel, bus.cmpmux_sel, bus.aluop,
                   bus.cmpop, bus.mem_read, bus.mem_write, bus.mem_byte_enable};
            checks++;
            if (act !== cmp_s.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", cmp_s.name, act, cmp_s.exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        outs_t o;
        bus.opcode = op_imm; bus.funct3 = '0; bus.funct7 = '0;
        bus.br_en = 1'b0; bus.select = '0; bus.mem_resp = 1'b0;

        // Reset held from time zero: FETCH1 outputs.
        set_insn(op_imm, 3'd0, 7'h00, 1'b0, 2'd0);
        o = base(3'd0); o.ld_mar = 1;
        push(0, 0, o, "rst.hold0");
        push(0, 1, o, "rst.hold1");

        add_insn("addi", op_imm, 3'd0, 7'h00, 0, 0, 0, 0, 0, n);
        check_lit("addi.cycles", n, 5);
        add_insn("beq_taken", op_br, 3'd0, 7'h00, 1, 0, 0, 0, 0, n);
        add_insn("beq_not", op_br, 3'd0, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("sb_sel2", op_store, 3'd0, 7'h00, 0, 2, 0, 3, 0, n);
        check_lit("sb.cycles", n, 10);
        add_insn("lhu", op_load, 3'd5, 7'h00, 0, 0, 1, 0, 0, n);
        check_lit("lhu.cycles", n, 8);
        add_insn("sub", op_reg, 3'd0, 7'h20, 0, 0, 0, 0, 0, n);
        add_insn("srai", op_imm, 3'd5, 7'h20, 0, 0, 0, 0, 0, n);
        add_insn("illegal", 7'h7F, 3'd0, 7'h00, 0, 0, 0, 0, 0, n);
        check_lit("illegal.cycles", n, 4);
        add_insn("lui", op_lui, 3'd3, 7'h00, 0, 0, 2, 0, 1, n);
        add_insn("auipc", op_auipc, 3'd1, 7'h00, 0, 0, 0, 0, 1, n);
        add_insn("jal", op_jal, 3'd0, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("jalr", op_jalr, 3'd0, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("slti", op_imm, 3'd2, 7'h00, 1, 0, 0, 0, 0, n);
        add_insn("sltu", op_reg, 3'd3, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("xor", op_reg, 3'd4, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("srl", op_reg, 3'd5, 7'h00, 0, 0, 0, 0, 0, n);
        add_insn("andi", op_imm, 3'd7, 7'h20, 0, 0, 0, 0, 0, n);
        add_insn("bne_taken", op_br, 3'd1, 7'h00, 1, 0, 0, 0, 0, n);
        add_insn("sw", op_store, 3'd2, 7'h00, 0, 0, 0, 0, 1, n);
        add_insn("sh_sel1", op_store, 3'd1, 7'h00, 0, 1, 0, 1, 0, n);
        add_insn("sh_sel3", op_store, 3'd1, 7'h00, 0, 3, 0, 0, 0, n);
        add_insn("lw", op_load, 3'd2, 7'h00, 0, 0, 0, 2, 0, n);
        add_insn("lb", op_load, 3'd0, 7'h00, 0, 3, 1, 0, 1, n);

        // Reset asserted while FETCH2 waits on memory.
        set_insn(op_load, 3'd2, 7'h00, 0, 2'd0);
        o = base(3'd2); o.ld_mar = 1;
        push(1, 0, o, "rstmid.fetch1");
        o = base(3'd2); o.mrd = 1; o.ld_mdr = 1;
        push(1, 0, o, "rstmid.fetch2a");
        push(1, 0, o, "rstmid.fetch2b");
        o = base(3'd2); o.ld_mar = 1;
        push(0, 0, o, "rstmid.asserted");
        push(0, 1, o, "rstmid.held");
        add_insn("after_rst", op_imm, 3'd6, 7'h00, 0, 0, 0, 0, 0, n);

        // Literal pins on the model itself.
        check_lit("model.sb_sel2", byte_mask(3'd0, 2'd2), 32'h4);
        check_lit("model.sh_sel1", byte_mask(3'd1, 2'd1), 32'h6);
        check_lit("model.sh_sel3", byte_mask(3'd1, 2'd3), 32'h8);
        check_lit("model.sw", byte_mask(3'd2, 2'd1), 32'hF);
        o = exec_outs(op_reg, 3'd0, 7'h20, 1'b0);
        check_lit("model.sub_aluop", o.aluop, 32'd3);
        o = exec_outs(op_imm, 3'd5, 7'h20, 1'b0);
        check_lit("model.srai_aluop", o.aluop, 32'd2);
        o = exec_outs(op_br, 3'd0, 7'h00, 1'b1);
        check_lit("model.beq_pcmux", o.pcmux, 32'd1);
        check_lit("model.lhu_sel", load_sel(3'd5), 32'd8);

        @(posedge clk);
        #1;
        foreach (plan[i]) begin
            rst          = plan[i].rst;
            bus.mem_resp = plan[i].resp;
            bus.br_en    = plan[i].br;
            bus.select   = plan[i].sel;
            bus.opcode   = rv32i_opcode'(plan[i].op);
            bus.funct3   = plan[i].f3;
            bus.funct7   = plan[i].f7;
            exp_q.push_back(plan[i]);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
